fifo_packet_reader: RTL and testbench

FIFO_PACKET_READER -- requirements
Module: fifo_packet_reader

---
 rtl/fifo_packet_reader.sv | 143 ++++++++++++++
 tb/tb_fifo_packet_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_packet_reader.sv
// Reads length-prefixed packets from a registered-output synchronous FIFO and
// streams the payload through a 2-entry buffer with valid/ready handshaking.
module fifo_packet_reader #(
    parameter int DATA_WIDTH       = 16,
    parameter int MAX_PACKET_WORDS = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_read_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  length_error,
    output logic [15:0]           packet_count
);

    typedef enum logic [1:0] {IDLE, HDR_WAIT, PAYLOAD} state_t;

    localparam logic [DATA_WIDTH-1:0] MAX_LEN = DATA_WIDTH'(MAX_PACKET_WORDS);
    localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

    state_t                  state_reg, state_next;
    logic                    pending_reg;
    logic                    pending_hdr_reg;
    logic [DATA_WIDTH-1:0]   issue_reg, issue_next;
    logic [DATA_WIDTH-1:0]   deliver_reg;
    logic [1:0]              occ_reg;
    logic [DATA_WIDTH-1:0]   buf_data_reg [2];
    logic                    buf_last_reg [2];
    logic                    length_error_reg;
    logic [15:0]             packet_count_reg;

    logic                    rd_en, rd_hdr, deliver_load, hdr_bad;
    logic                    head_valid, pop, wr, space_ok;
    logic [1:0]              occ_after;
    logic [2:0]              fill;

    assign head_valid = (occ_reg != 2'd0);
    assign out_valid  = head_valid && !reset;
    assign out_data   = out_valid ? buf_data_reg[0] : '0;
    assign out_last   = out_valid && buf_last_reg[0];
    assign pop        = out_valid && out_ready;
    assign wr         = pending_reg && !pending_hdr_reg;

    // Space is judged after this cycle's pop so a draining buffer sustains one read per cycle.
    assign occ_after = occ_reg - {1'b0, pop};
    assign fill      = {1'b0, occ_after} + {2'b00, pending_reg};
    assign space_ok  = (fill < 3'd2);

    assign fifo_read_enable = rd_en && !reset;
    assign length_error     = length_error_reg && !reset;
    assign packet_count     = packet_count_reg;

    always_comb begin
        state_next   = state_reg;
        rd_en        = 1'b0;
        rd_hdr       = 1'b0;
        issue_next   = issue_reg;
        deliver_load = 1'b0;
        hdr_bad      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!pending_reg && !fifo_empty) begin
                    rd_en      = 1'b1;
                    rd_hdr     = 1'b1;
                    state_next = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                if (pending_reg && pending_hdr_reg) begin
                    if (fifo_read_data != '0 && fifo_read_data <= MAX_LEN) begin
                        issue_next   = fifo_read_data;
                        deliver_load = 1'b1;
                        state_next   = PAYLOAD;
                    end else begin
                        hdr_bad    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                if (issue_reg != '0 && !fifo_empty && space_ok) begin
                    rd_en      = 1'b1;
                    issue_next = issue_reg - ONE;
                    if (issue_reg == ONE) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            pending_reg      <= 1'b0;
            pending_hdr_reg  <= 1'b0;
            issue_reg        <= '0;
            deliver_reg      <= '0;
            occ_reg          <= 2'd0;
            length_error_reg <= 1'b0;
            packet_count_reg <= 16'd0;
        end else begin
            state_reg        <= state_next;
            pending_reg      <= fifo_read_enable;
            pending_hdr_reg  <= rd_hdr;
            issue_reg        <= issue_next;
            length_error_reg <= hdr_bad;
            occ_reg          <= occ_after + {1'b0, wr};
            if (deliver_load) begin
                deliver_reg <= fifo_read_data;
            end else if (wr) begin
                deliver_reg <= deliver_reg - ONE;
            end
            if (pop && buf_last_reg[0]) begin
                packet_count_reg <= packet_count_reg + 16'd1;
            end
        end
    end

    // Entry 0 is the head; a pop shifts entry 1 forward, and a write lands at occ_after.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            always_ff @(posedge clock) begin
                if (reset) begin
                    buf_data_reg[gi] <= '0;
                    buf_last_reg[gi] <= 1'b0;
                end else if (wr && occ_after[0] == gi[0]) begin
                    buf_data_reg[gi] <= fifo_read_data;
                    buf_last_reg[gi] <= (deliver_reg == ONE);
                end else if (pop && gi == 0) begin
                    buf_data_reg[gi] <= buf_data_reg[1];
                    buf_last_reg[gi] <= buf_last_reg[1];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Directed bench: a small FIFO model feeds fifo_packet_reader; a negedge
// monitor records transfers, length errors and reads for the checks below.
module tb_fifo_packet_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [15:0] fifo_read_data = 16'd0;
    logic        fifo_read_enable;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        length_error;
    logic [15:0] packet_count;

    logic        hold_empty;
    logic        flush;
    logic [15:0] mem [0:63];
    int          wr_ptr;
    int          rd_ptr = 0;

    int          checks = 0;
    int          errors = 0;

    logic [15:0] rx_data [0:63];
    logic        rx_last [0:63];
    int          rx_cyc  [0:63];
    int          rx_n = 0;
    int          lerr_n = 0;
    int          rd_n = 0;
    int          viol_n = 0;
    int          cyc = 0;

    fifo_packet_reader #(.DATA_WIDTH(16), .MAX_PACKET_WORDS(1024)) dut (
        .clock            (clock),
        .reset            (reset),
        .fifo_empty       (fifo_empty),
        .fifo_read_data   (fifo_read_data),
        .fifo_read_enable (fifo_read_enable),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_last         (out_last),
        .out_ready        (out_ready),
        .length_error     (length_error),
        .packet_count     (packet_count)
    );

    always #5 clock = ~clock;

    assign fifo_empty = (rd_ptr == wr_ptr) || hold_empty;

    // Registered-read FIFO model: data appears the cycle after the enable.
    always @(posedge clock) begin
        if (fifo_read_enable) fifo_read_data <= mem[rd_ptr % 64];
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_read_enable) rd_ptr <= rd_ptr + 1;
    end

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (out_valid && out_ready) begin
            rx_data[rx_n % 64] = out_data;
            rx_last[rx_n % 64] = out_last;
            rx_cyc[rx_n % 64]  = cyc;
            rx_n = rx_n + 1;
            $display("xfer data=%04h last=%0d count=%0d", out_data, out_last, packet_count);
        end
        if (length_error) lerr_n = lerr_n + 1;
        if (fifo_read_enable) rd_n = rd_n + 1;
        if (fifo_read_enable && fifo_empty) viol_n = viol_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_rx(input string tag, input int target);
        int k;
        k = 0;
        while (rx_n < target && k < 300) begin
            tick(1);
            k++;
        end
        check(tag, 32'(rx_n), 32'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lb, rb;
        logic found;
        reset = 1'b1;
        out_ready = 1'b1;
        hold_empty = 1'b0;
        flush = 1'b0;
        wr_ptr = 0;

        // Reset: FIFO already non-empty, yet nothing may be read or presented.
        push(16'd3); push(16'hA001); push(16'hB002); push(16'hC003);
        tick(3);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_rden", 32'(fifo_read_enable), 32'd0);
        check("rst_lerr", 32'(length_error), 32'd0);
        check("rst_pcount", 32'(packet_count), 32'd0);

        // {3,A,B,C} streamed back to back
        base = rx_n;
        reset = 1'b0;
        wait_rx("p3_done", base + 3);
        check("p3_w0", 32'(rx_data[base]), 32'hA001);
        check("p3_w1", 32'(rx_data[base+1]), 32'hB002);
        check("p3_w2", 32'(rx_data[base+2]), 32'hC003);
        check("p3_last0", 32'(rx_last[base]), 32'd0);
        check("p3_last1", 32'(rx_last[base+1]), 32'd0);
        check("p3_last2", 32'(rx_last[base+2]), 32'd1);
        check("p3_consec01", 32'(rx_cyc[base+1] - rx_cyc[base]), 32'd1);
        check("p3_consec12", 32'(rx_cyc[base+2] - rx_cyc[base+1]), 32'd1);
        tick(2);
        check("p3_pcount", 32'(packet_count), 32'd1);

        // Zero-length header, then {1,D}
        lb = lerr_n; base = rx_n;
        push(16'd0);
        tick(6);
        check("len0_pulses", 32'(lerr_n - lb), 32'd1);
        check("len0_no_out", 32'(rx_n - base), 32'd0);
        push(16'd1); push(16'hD00D);
        wait_rx("p1_done", base + 1);
        check("p1_data", 32'(rx_data[base]), 32'hD00D);
        check("p1_last", 32'(rx_last[base]), 32'd1);
        tick(2);
        check("p1_pcount", 32'(packet_count), 32'd2);

        // Oversize header: error, no payload reads, next header {1,E} works
        lb = lerr_n; rb = rd_n; base = rx_n;
        push(16'd1025); push(16'd1); push(16'hE0E0);
        wait_rx("big_next_done", base + 1);
        tick(3);
        check("big_pulses", 32'(lerr_n - lb), 32'd1);
        check("big_reads", 32'(rd_n - rb), 32'd3);
        check("big_next_data", 32'(rx_data[base]), 32'hE0E0);
        check("big_next_last", 32'(rx_last[base]), 32'd1);
        check("big_pcount", 32'(packet_count), 32'd3);

        // Backpressure: {4,W0..W3} with out_ready low for a while
        out_ready = 1'b0;
        rb = rd_n; base = rx_n;
        push(16'd4); push(16'h5A00); push(16'h5A01); push(16'h5A02); push(16'h5A03);
        tick(12);
        check("bp_reads", 32'(rd_n - rb), 32'd3);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_hold_a", 32'(out_data), 32'h5A00);
        tick(1);
        check("bp_hold_b", 32'(out_data), 32'h5A00);
        check("bp_hold_last", 32'(out_last), 32'd0);
        out_ready = 1'b1;
        wait_rx("bp_done", base + 4);
        for (int i = 0; i < 4; i++) begin
            check("bp_word", 32'(rx_data[base+i]), 32'h5A00 + 32'(i));
            check("bp_last", 32'(rx_last[base+i]), (i == 3) ? 32'd1 : 32'd0);
        end
        tick(2);
        check("bp_pcount", 32'(packet_count), 32'd4);

        // fifo_empty toggling mid-packet
        base = rx_n;
        push(16'd6);
        for (int i = 0; i < 6; i++) push(16'h6600 + 16'(i));
        for (int i = 0; i < 40; i++) begin
            hold_empty = ($urandom_range(0, 1) == 1);
            tick(1);
        end
        hold_empty = 1'b0;
        wait_rx("tog_done", base + 6);
        tick(3);
        check("tog_count", 32'(rx_n - base), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("tog_word", 32'(rx_data[base+i]), 32'h6600 + 32'(i));
            check("tog_last", 32'(rx_last[base+i]), (i == 5) ? 32'd1 : 32'd0);
        end
        check("tog_pcount", 32'(packet_count), 32'd5);

        // Reset during the second payload word of a 5-word packet
        base = rx_n;
        push(16'd5);
        for (int i = 0; i < 5; i++) push(16'h7700 + 16'(i));
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (out_valid && out_data == 16'h7701) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_found_w1", 32'(found), 32'd1);
        reset = 1'b1;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_pcount", 32'(packet_count), 32'd0);
        reset = 1'b0;
        tick(4);
        check("mid_rx_before", 32'(rx_n - base), 32'd1);
        check("mid_quiet", 32'(out_valid), 32'd0);
        base = rx_n;
        push(16'd2); push(16'h8800); push(16'h8801);
        wait_rx("post_done", base + 2);
        tick(3);
        check("post_count", 32'(rx_n - base), 32'd2);
        check("post_w0", 32'(rx_data[base]), 32'h8800);
        check("post_w1", 32'(rx_data[base+1]), 32'h8801);
        check("post_last0", 32'(rx_last[base]), 32'd0);
        check("post_last1", 32'(rx_last[base+1]), 32'd1);
        check("post_pcount", 32'(packet_count), 32'd1);

        check("rd_while_empty", 32'(viol_n), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
